// File: rtl/mem_pattern_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pattern_master_pkg
//  Description : Shared bus package for the memory pattern master. Holds the
//                default bus widths, control-bit positions and the FSM state
//                encoding used by the interface, the top and the testbench.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pattern_master_pkg;

    localparam int c_BUS_WIDTH  = 32;
    localparam int c_CTRL_WIDTH = 8;

    // Control bit positions within ctrl_out
    localparam int c_CTRL_VALID = 0;   // address-phase valid
    localparam int c_CTRL_WRITE = 1;   // write transfer

    localparam int c_ADDR_WIDTH = 24;
    localparam int c_CNT_WIDTH  = 16;
    localparam int c_SEED_WIDTH = 32;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_WR_REQ  = 4'd1,
        S_WR_ADDR = 4'd2,
        S_WR_DATA = 4'd3,
        S_WR_GAP  = 4'd4,
        S_RD_REQ  = 4'd5,
        S_RD_ADDR = 4'd6,
        S_RD_WAIT = 4'd7,
        S_RD_GAP  = 4'd8,
        S_DONE    = 4'd9
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_pattern_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pattern_master_if
//  Description : Arbiter-side bus bundle of the pattern master.
//                master : drives req, bus_out, ctrl_out; receives ack,
//                         bus_in, ctrl_in, ready_in
//                slave  : the opposite directions (arbiter / memory model)
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_pattern_master_if
    import mem_pattern_master_pkg::*;
#(
    parameter int BUS_WIDTH  = c_BUS_WIDTH,
    parameter int CTRL_WIDTH = c_CTRL_WIDTH
) ();

    logic                  req;
    logic                  ack;
    logic [BUS_WIDTH-1:0]  bus_out;
    logic [CTRL_WIDTH-1:0] ctrl_out;
    logic [BUS_WIDTH-1:0]  bus_in;
    logic [CTRL_WIDTH-1:0] ctrl_in;
    logic                  ready_in;

    modport master (
        output req, bus_out, ctrl_out,
        input  ack, bus_in, ctrl_in, ready_in
    );

    modport slave (
        input  req, bus_out, ctrl_out,
        output ack, bus_in, ctrl_in, ready_in
    );

endinterface
`default_nettype wire

// File: rtl/mem_pattern_master_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pattern_gen
//  Description : Address/data generator for word index i of a test run.
//                addr = (base + i) mod 2^24, data = (seed + i) mod 2^32.
//  Ports       : i_base_addr, i_seed, i_index in; o_addr, o_data out
//  Revision    : 1.0 - initial release
// ============================================================================
module pattern_gen
    import mem_pattern_master_pkg::*;
(
    input  wire  [c_ADDR_WIDTH-1:0] i_base_addr,
    input  wire  [c_SEED_WIDTH-1:0] i_seed,
    input  wire  [c_CNT_WIDTH-1:0]  i_index,
    output logic [c_ADDR_WIDTH-1:0] o_addr,
    output logic [c_SEED_WIDTH-1:0] o_data
);

    // Natural modular wrap of the fixed-width adders gives the mod arithmetic
    assign o_addr = i_base_addr + c_ADDR_WIDTH'(i_index);
    assign o_data = i_seed + c_SEED_WIDTH'(i_index);

endmodule
`default_nettype wire

// File: rtl/mem_pattern_master.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pattern_master
//  Description : Memory test master. Writes an incrementing pattern to a range
//                of words through an arbitrated bus, reads it back, counts
//                mismatches and aborts on a slave that never completes.
//  Ports       : clk, rst                      clock / sync active-high reset
//                start, base_addr, count, seed run request and parameters
//                bus (master modport)          req/ack/bus/ctrl/ready_in
//                busy, done, pass, timeout     run status
//                err_count, first_err_addr     checker results
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_pattern_master
    import mem_pattern_master_pkg::*;
#(
    parameter int BUS_WIDTH  = c_BUS_WIDTH,
    parameter int CTRL_WIDTH = c_CTRL_WIDTH,
    parameter int TIMEOUT    = 255
)
(
    input  wire                     clk,
    input  wire                     rst,
    input  wire                     start,
    input  wire  [c_ADDR_WIDTH-1:0] base_addr,
    input  wire  [c_CNT_WIDTH-1:0]  count,
    input  wire  [c_SEED_WIDTH-1:0] seed,
    mem_pattern_master_if.master    bus,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic                    timeout,
    output logic [c_CNT_WIDTH-1:0]  err_count,
    output logic [c_ADDR_WIDTH-1:0] first_err_addr
);

    localparam int c_TMR_WIDTH = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t                  r_state;
    state_t                  w_next;
    logic [c_ADDR_WIDTH-1:0] r_base;
    logic [c_CNT_WIDTH-1:0]  r_count;
    logic [c_SEED_WIDTH-1:0] r_seed;
    logic [c_CNT_WIDTH-1:0]  r_index;
    logic [c_TMR_WIDTH-1:0]  r_tmr;
    logic [c_CNT_WIDTH-1:0]  r_err_count;
    logic [c_ADDR_WIDTH-1:0] r_first_err;
    logic                    r_pass;
    logic                    r_timeout;

    logic [c_ADDR_WIDTH-1:0] w_addr;
    logic [c_SEED_WIDTH-1:0] w_data;
    logic [BUS_WIDTH-1:0]    w_addr_bus;
    logic [BUS_WIDTH-1:0]    w_data_bus;
    logic                    w_last;
    logic                    w_tmr_exp;
    logic                    w_req;
    logic [BUS_WIDTH-1:0]    w_bus_out;
    logic [CTRL_WIDTH-1:0]   w_ctrl_out;
    logic                    w_unused_ctrl;

    pattern_gen u_pattern_gen (
        .i_base_addr (r_base),
        .i_seed      (r_seed),
        .i_index     (r_index),
        .o_addr      (w_addr),
        .o_data      (w_data)
    );

    assign w_addr_bus    = BUS_WIDTH'(w_addr);
    assign w_data_bus    = BUS_WIDTH'(w_data);
    assign w_last        = (r_index == (r_count - 16'd1));
    // Expires on the TIMEOUT-th consecutive cycle without ready_in
    assign w_tmr_exp     = (r_tmr == c_TMR_WIDTH'(TIMEOUT - 1));
    assign w_unused_ctrl = ^bus.ctrl_in;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and bus outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next     = r_state;
        w_req      = 1'b0;
        w_bus_out  = '0;
        w_ctrl_out = '0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (count == 16'd0) ? S_DONE : S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                w_req = 1'b1;
                if (bus.ack) w_next = S_WR_ADDR;
            end
            S_WR_ADDR: begin
                w_req                    = 1'b1;
                w_bus_out                = w_addr_bus;
                w_ctrl_out[c_CTRL_VALID] = 1'b1;
                w_ctrl_out[c_CTRL_WRITE] = 1'b1;
                w_next                   = S_WR_DATA;
            end
            S_WR_DATA: begin
                w_req                    = 1'b1;
                w_bus_out                = w_data_bus;
                w_ctrl_out[c_CTRL_WRITE] = 1'b1;
                if (bus.ready_in)   w_next = S_WR_GAP;
                else if (w_tmr_exp) w_next = S_DONE;
            end
            S_WR_GAP: begin
                w_next = w_last ? S_RD_REQ : S_WR_REQ;
            end
            S_RD_REQ: begin
                w_req = 1'b1;
                if (bus.ack) w_next = S_RD_ADDR;
            end
            S_RD_ADDR: begin
                w_req                    = 1'b1;
                w_bus_out                = w_addr_bus;
                w_ctrl_out[c_CTRL_VALID] = 1'b1;
                w_next                   = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                w_req = 1'b1;
                if (bus.ready_in)   w_next = S_RD_GAP;
                else if (w_tmr_exp) w_next = S_DONE;
            end
            S_RD_GAP: begin
                w_next = w_last ? S_DONE : S_RD_REQ;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Run parameters, index, timeout counter and checker
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_base      <= '0;
            r_count     <= '0;
            r_seed      <= '0;
            r_index     <= '0;
            r_tmr       <= '0;
            r_err_count <= '0;
            r_first_err <= '0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base      <= base_addr;
                        r_count     <= count;
                        r_seed      <= seed;
                        r_index     <= '0;
                        r_err_count <= '0;
                        r_first_err <= '0;
                        r_timeout   <= 1'b0;
                        // An empty run passes trivially; otherwise pass is
                        // decided after the last readback.
                        r_pass      <= (count == 16'd0);
                    end
                end
                S_WR_ADDR, S_RD_ADDR: begin
                    r_tmr <= '0;
                end
                S_WR_DATA, S_RD_WAIT: begin
                    if (!bus.ready_in) begin
                        r_tmr <= r_tmr + c_TMR_WIDTH'(1);
                        if (w_tmr_exp) r_timeout <= 1'b1;
                    end else if ((r_state == S_RD_WAIT) && (bus.bus_in != w_data_bus)) begin
                        if (r_err_count == 16'd0)    r_first_err <= w_addr;
                        if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
                    end
                end
                S_WR_GAP: begin
                    r_index <= w_last ? 16'd0 : (r_index + 16'd1);
                end
                S_RD_GAP: begin
                    if (w_last) r_pass <= (r_err_count == 16'd0);
                    else        r_index <= r_index + 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req        = w_req;
    assign bus.bus_out    = w_bus_out;
    assign bus.ctrl_out   = w_ctrl_out;
    assign busy           = (r_state != S_IDLE);
    assign done           = (r_state == S_DONE);
    assign pass           = r_pass;
    assign timeout        = r_timeout;
    assign err_count      = r_err_count;
    assign first_err_addr = r_first_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_pattern_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mem_pattern_master
//  Description : Self-checking bench for mem_pattern_master. A behavioural
//                arbiter/memory slave answers the bus; expected addresses,
//                data and checker results come from the word formulas.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_pattern_master;
    import mem_pattern_master_pkg::*;

    localparam int c_TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [23:0] base_addr;
    logic [15:0] count;
    logic [31:0] seed;
    logic        busy, done, pass, timeout;
    logic [15:0] err_count;
    logic [23:0] first_err_addr;

    mem_pattern_master_if #(.BUS_WIDTH(32), .CTRL_WIDTH(8)) bus_if ();

    mem_pattern_master #(
        .BUS_WIDTH  (32),
        .CTRL_WIDTH (8),
        .TIMEOUT    (c_TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .base_addr      (base_addr),
        .count          (count),
        .seed           (seed),
        .bus            (bus_if),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .timeout        (timeout),
        .err_count      (err_count),
        .first_err_addr (first_err_addr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Slave configuration
    int          ack_delay, ready_delay;
    bit          no_ready, corrupt_en, stray_en;
    logic [23:0] corrupt_addr;
    // Slave runtime state
    int          req_cycles, pend, wcnt;
    logic [23:0] paddr;
    logic [31:0] mem [int];
    // Observations
    logic [23:0] wr_a[$], rd_a[$];
    logic [31:0] wr_d[$];
    int          wr_data_cycles;
    bit          saw_req;

    task automatic check_value(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of the arbiter + memory slave, called #1 after the edge.
    task automatic slave_step();
        logic [31:0] rdata;
        if (bus_if.req) saw_req = 1'b1;
        if (bus_if.ctrl_out == 8'h02) wr_data_cycles++;
        if (bus_if.req) req_cycles++; else req_cycles = 0;
        bus_if.ack      = (req_cycles > ack_delay) && ($urandom_range(0, 5) != 0);
        bus_if.ready_in = 1'b0;
        bus_if.bus_in   = $urandom;
        if (pend != 0) begin
            if (!no_ready && wcnt >= ready_delay) begin
                bus_if.ready_in = 1'b1;
                if (pend == 1) begin
                    wr_d.push_back(bus_if.bus_out);
                    mem[int'(paddr)] = bus_if.bus_out;
                end else begin
                    rdata = mem.exists(int'(paddr)) ? mem[int'(paddr)] : 32'h0;
                    if (corrupt_en && paddr == corrupt_addr) rdata = rdata ^ 32'h0000_0100;
                    bus_if.bus_in = rdata;
                end
                pend = 0;
            end else begin
                wcnt++;
            end
        end else if (stray_en && $urandom_range(0, 3) == 0) begin
            bus_if.ready_in = 1'b1;
        end
        if (bus_if.ctrl_out[c_CTRL_VALID]) begin
            paddr = bus_if.bus_out[23:0];
            wcnt  = 0;
            if (bus_if.ctrl_out[c_CTRL_WRITE]) begin
                pend = 1;
                wr_a.push_back(paddr);
            end else begin
                pend = 2;
                rd_a.push_back(paddr);
            end
        end
    endtask

    task automatic clear_slave();
        pend = 0; req_cycles = 0; wcnt = 0;
        wr_a.delete(); rd_a.delete(); wr_d.delete();
        wr_data_cycles = 0; saw_req = 1'b0;
        bus_if.ack = 1'b0; bus_if.ready_in = 1'b0;
    endtask

    task automatic run_test(input string tag, input logic [23:0] b, input int n, input logic [31:0] s,
                            input int ad, input int rdl, input bit cen, input logic [23:0] ca,
                            input bit nr, input bit mid_start);
        int          cyc, done_cyc, exp_err;
        bit          done_seen, req_at_done, exp_to, exp_pass;
        logic [23:0] ea, exp_first, got_a;
        logic [31:0] got_d;
        ack_delay = ad; ready_delay = rdl; corrupt_en = cen; corrupt_addr = ca; no_ready = nr;
        clear_slave();
        base_addr = b; count = 16'(n); seed = s; start = 1'b1;
        tick();
        start = 1'b0;
        base_addr = $urandom; count = $urandom; seed = $urandom;
        cyc = 0; done_seen = 1'b0; done_cyc = -1; req_at_done = 1'b0;
        while (!done_seen && cyc < 20000) begin
            slave_step();
            if (done) begin
                done_seen = 1'b1; done_cyc = cyc; req_at_done = bus_if.req;
            end
            start = mid_start && (cyc == 2);
            if (cyc == 0) check_value({tag, ".busy"}, busy, 1'b1);
            tick();
            cyc++;
        end
        start = 1'b0;
        check_value({tag, ".done_seen"}, done_seen, 1'b1);
        check_value({tag, ".done_pulse"}, done, 1'b0);
        check_value({tag, ".busy_after"}, busy, 1'b0);

        exp_to = nr && (n != 0);
        exp_err = 0; exp_first = 24'h0;
        if (!exp_to) begin
            for (int i = 0; i < n; i++) begin
                ea = 24'(b + 24'(i));
                if (cen && ea == ca) begin
                    if (exp_err == 0) exp_first = ea;
                    exp_err++;
                end
            end
        end
        exp_pass = (exp_err == 0) && !exp_to;
        check_value({tag, ".err_count"}, err_count, 16'(exp_err));
        check_value({tag, ".first_err_addr"}, first_err_addr, exp_first);
        check_value({tag, ".pass"}, pass, exp_pass);
        check_value({tag, ".timeout"}, timeout, exp_to);

        if (n == 0) begin
            check_value({tag, ".no_req"}, saw_req, 1'b0);
            check_value({tag, ".done_latency"}, (done_cyc >= 0 && done_cyc <= 1), 1'b1);
        end else if (exp_to) begin
            check_value({tag, ".to_wr_cycles"}, wr_data_cycles, c_TIMEOUT);
            check_value({tag, ".to_req_low"}, req_at_done, 1'b0);
            check_value({tag, ".to_nwrites"}, wr_a.size(), 1);
            check_value({tag, ".to_nreads"}, rd_a.size(), 0);
        end else begin
            check_value({tag, ".nwrites"}, wr_d.size(), n);
            check_value({tag, ".nreads"}, rd_a.size(), n);
            for (int i = 0; i < n; i++) begin
                ea    = 24'(b + 24'(i));
                got_a = (i < wr_a.size()) ? wr_a[i] : 24'hxxxxxx;
                check_value({tag, ".wr_addr"}, got_a, ea);
                got_d = (i < wr_d.size()) ? wr_d[i] : 32'hxxxxxxxx;
                check_value({tag, ".wr_data"}, got_d, 32'(s + 32'(i)));
                got_a = (i < rd_a.size()) ? rd_a[i] : 24'hxxxxxx;
                check_value({tag, ".rd_addr"}, got_a, ea);
            end
        end
        // Results hold while idle
        tick();
        check_value({tag, ".hold_err"}, err_count, 16'(exp_err));
        check_value({tag, ".hold_pass"}, pass, exp_pass);
    endtask

    // Reset asserted while the third read waits for a slow slave
    task automatic reset_test();
        int  cyc;
        bit  hit;
        ack_delay = 2; ready_delay = 40; corrupt_en = 1'b1; corrupt_addr = 24'h000200;
        no_ready = 1'b0; stray_en = 1'b0;
        clear_slave();
        base_addr = 24'h000200; count = 16'd4; seed = 32'h1234_0000; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0; hit = 1'b0;
        while (!hit && cyc < 5000) begin
            slave_step();
            if (pend == 2 && rd_a.size() == 3 && wcnt >= 3) hit = 1'b1;
            else begin
                tick();
                cyc++;
            end
        end
        check_value("rst.reached_rd_wait", hit, 1'b1);
        check_value("rst.req_before", bus_if.req, 1'b1);
        check_value("rst.err_before", err_count, 16'd1);
        rst = 1'b1;
        tick();
        check_value("rst.req", bus_if.req, 1'b0);
        check_value("rst.ctrl_out", bus_if.ctrl_out, 8'h00);
        check_value("rst.bus_out", bus_if.bus_out, 32'h0);
        check_value("rst.busy", busy, 1'b0);
        check_value("rst.done", done, 1'b0);
        check_value("rst.pass", pass, 1'b0);
        check_value("rst.timeout", timeout, 1'b0);
        check_value("rst.err_count", err_count, 16'd0);
        check_value("rst.first_err", first_err_addr, 24'h0);
        rst = 1'b0;
        clear_slave();
        tick();
        run_test("after_rst", 24'h000200, 4, 32'h1234_0000, 2, 1, 1'b0, 24'h0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [23:0] rb, rca;
        int          rn;
        rst = 1'b1; start = 1'b0; base_addr = '0; count = '0; seed = '0;
        ack_delay = 0; ready_delay = 0; no_ready = 1'b0; corrupt_en = 1'b0; stray_en = 1'b0;
        corrupt_addr = '0; paddr = '0;
        clear_slave();
        bus_if.bus_in = '0; bus_if.ctrl_in = '0;
        repeat (3) tick();
        check_value("reset.req", bus_if.req, 1'b0);
        check_value("reset.busy", busy, 1'b0);
        check_value("reset.done", done, 1'b0);
        check_value("reset.pass", pass, 1'b0);
        check_value("reset.err_count", err_count, 16'd0);
        rst = 1'b0;
        bus_if.ctrl_in = 8'hA5;
        tick();

        run_test("basic",   24'h000010, 4, 32'hA5A5_0000, 0, 0, 1'b0, 24'h0,      1'b0, 1'b0);
        run_test("corrupt", 24'h000010, 4, 32'hA5A5_0000, 1, 1, 1'b1, 24'h000012, 1'b0, 1'b0);
        run_test("count0",  24'h123456, 0, 32'hDEAD_BEEF, 0, 0, 1'b0, 24'h0,      1'b0, 1'b0);
        run_test("wrap",    24'hFFFFFE, 3, 32'hFFFF_FFFF, 1, 2, 1'b0, 24'h0,      1'b0, 1'b0);
        run_test("timeout", 24'h000100, 2, 32'h0000_0001, 0, 0, 1'b0, 24'h0,      1'b1, 1'b0);
        reset_test();

        for (int t = 0; t < 10; t++) begin
            rb  = $urandom_range(0, 1) ? 24'(24'hFFFFF8 + 24'($urandom_range(0, 7))) : 24'($urandom);
            rn  = $urandom_range(1, 12);
            rca = 24'(rb + 24'($urandom_range(0, rn - 1)));
            stray_en = $urandom_range(0, 1);
            run_test("random", rb, rn, $urandom, $urandom_range(0, 3), $urandom_range(0, 4),
                     1'($urandom_range(0, 1)), rca, 1'b0, 1'($urandom_range(0, 1)));
        end
        stray_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
